// File: rtl/uart_alu_frame_ctrl.sv
// uart_alu_frame_ctrl
// Collects an operand/opcode frame from a UART RX FIFO (operand A bytes,
// operand B bytes, then one opcode byte, each operand LSB byte first),
// presents the operands and opcode to an ALU, captures the ALU result after
// ALU_LATENCY cycles and streams it back LSB byte first into a UART TX FIFO.
// A frame that stalls part-way for TIMEOUT_CYCLES idle cycles is discarded.
//
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_rx_empty, i_r_data RX FIFO status and head word
//   i_tx_full            TX FIFO full (back-pressure)
//   i_result_data        ALU result
//   o_rd_uart            RX pop strobe (combinational)
//   o_wr_uart, o_w_data  TX push strobe (combinational) and TX word
//   o_op_a, o_op_b       operands, held until the next opcode pop
//   o_op_code            opcode (low OPCODE_SZ bits of the opcode byte)
//   o_busy               frame in progress
//   o_frame_done         one-cycle pulse after the last result byte push
//   o_frame_err          one-cycle pulse on inactivity abort
module uart_alu_frame_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_BYTES       = 2,
  parameter int RES_BYTES      = 2,
  parameter int OPCODE_SZ      = 6,
  parameter int ALU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_rx_empty,
  input  logic [DATA_WIDTH-1:0]           i_r_data,
  input  logic                            i_tx_full,
  input  logic [DATA_WIDTH*RES_BYTES-1:0] i_result_data,
  output logic                            o_rd_uart,
  output logic                            o_wr_uart,
  output logic [DATA_WIDTH-1:0]           o_w_data,
  output logic [DATA_WIDTH*OP_BYTES-1:0]  o_op_a,
  output logic [DATA_WIDTH*OP_BYTES-1:0]  o_op_b,
  output logic [OPCODE_SZ-1:0]            o_op_code,
  output logic                            o_busy,
  output logic                            o_frame_done,
  output logic                            o_frame_err
);

  localparam int OP_SZ     = DATA_WIDTH * OP_BYTES;
  localparam int RES_SZ    = DATA_WIDTH * RES_BYTES;
  localparam int MAX_BYTES = (OP_BYTES > RES_BYTES) ? OP_BYTES : RES_BYTES;
  localparam int IDX_W     = $clog2(MAX_BYTES + 1);
  localparam int LAT_W     = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam int TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] OP_LAST  = IDX_W'(OP_BYTES - 1);
  localparam logic [IDX_W-1:0] RES_LAST = IDX_W'(RES_BYTES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LATENCY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    ST_RX_A  = 3'd0,
    ST_RX_B  = 3'd1,
    ST_RX_OP = 3'd2,
    ST_EXEC  = 3'd3,
    ST_TX    = 3'd4
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic [OP_SZ-1:0]     shadow_a_r, shadow_a_nxt_s;
  logic [OP_SZ-1:0]     shadow_b_r, shadow_b_nxt_s;
  logic [OP_SZ-1:0]     op_a_r, op_a_nxt_s;
  logic [OP_SZ-1:0]     op_b_r, op_b_nxt_s;
  logic [OPCODE_SZ-1:0] op_code_r, op_code_nxt_s;
  logic [LAT_W-1:0]     lat_cnt_r, lat_cnt_nxt_s;
  logic [RES_SZ-1:0]    shift_r, shift_nxt_s;
  logic [TMO_W-1:0]     tmo_cnt_r, tmo_cnt_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 frame_done_r, frame_done_nxt_s;
  logic                 frame_err_r, frame_err_nxt_s;

  logic rx_phase_s;
  logic pop_s;
  logic push_s;
  logic partial_s;
  logic tmo_hit_s;

  // Upper bits of the opcode byte are deliberately discarded.
  generate
    if (OPCODE_SZ < DATA_WIDTH) begin : g_opcode_pad
      logic unused_rdata_s;
      assign unused_rdata_s = ^i_r_data[DATA_WIDTH-1:OPCODE_SZ];
    end
  endgenerate

  assign rx_phase_s = (state_r == ST_RX_A) || (state_r == ST_RX_B) ||
                      (state_r == ST_RX_OP);
  // Popping is suppressed during reset so the FIFO loses nothing.
  assign pop_s      = rx_phase_s && !i_rx_empty && !i_reset;
  assign push_s     = (state_r == ST_TX) && !i_tx_full;
  // Partial frame: at least one byte consumed but the opcode not yet popped.
  assign partial_s  = ((state_r == ST_RX_A) && (idx_r != {IDX_W{1'b0}})) ||
                      (state_r == ST_RX_B) || (state_r == ST_RX_OP);
  // Abort in the cycle the idle count reaches its limit unless a word arrives.
  assign tmo_hit_s  = TMO_EN && partial_s && !pop_s && (tmo_cnt_r == TMO_LAST);

  assign o_rd_uart    = pop_s;
  assign o_wr_uart    = push_s;
  assign o_w_data     = shift_r[DATA_WIDTH-1:0];
  assign o_op_a       = op_a_r;
  assign o_op_b       = op_b_r;
  assign o_op_code    = op_code_r;
  assign o_busy       = busy_r;
  assign o_frame_done = frame_done_r;
  assign o_frame_err  = frame_err_r;

  // Next-state and next-register computation for the frame controller.
  always_comb begin
    state_nxt_s      = state_r;
    idx_nxt_s        = idx_r;
    shadow_a_nxt_s   = shadow_a_r;
    shadow_b_nxt_s   = shadow_b_r;
    op_a_nxt_s       = op_a_r;
    op_b_nxt_s       = op_b_r;
    op_code_nxt_s    = op_code_r;
    lat_cnt_nxt_s    = lat_cnt_r;
    shift_nxt_s      = shift_r;
    tmo_cnt_nxt_s    = tmo_cnt_r;
    frame_done_nxt_s = 1'b0;
    frame_err_nxt_s  = 1'b0;
    busy_nxt_s       = 1'b0;

    case (state_r)
      ST_RX_A: begin
        if (pop_s) begin
          for (int i = 0; i < OP_BYTES; i++) begin
            if (idx_r == IDX_W'(i)) begin
              shadow_a_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] = i_r_data;
            end else begin
              shadow_a_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] =
                shadow_a_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          if (idx_r == OP_LAST) begin
            state_nxt_s = ST_RX_B;
            idx_nxt_s   = {IDX_W{1'b0}};
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_RX_A;
        end
      end
      ST_RX_B: begin
        if (pop_s) begin
          for (int i = 0; i < OP_BYTES; i++) begin
            if (idx_r == IDX_W'(i)) begin
              shadow_b_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] = i_r_data;
            end else begin
              shadow_b_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] =
                shadow_b_r[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          if (idx_r == OP_LAST) begin
            state_nxt_s = ST_RX_OP;
            idx_nxt_s   = {IDX_W{1'b0}};
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_RX_B;
        end
      end
      ST_RX_OP: begin
        // Operands and opcode are published together on the opcode pop.
        if (pop_s) begin
          op_a_nxt_s    = shadow_a_r;
          op_b_nxt_s    = shadow_b_r;
          op_code_nxt_s = i_r_data[OPCODE_SZ-1:0];
          lat_cnt_nxt_s = {LAT_W{1'b0}};
          state_nxt_s   = ST_EXEC;
        end else begin
          state_nxt_s = ST_RX_OP;
        end
      end
      ST_EXEC: begin
        if (lat_cnt_r == LAT_LAST) begin
          shift_nxt_s   = i_result_data;
          lat_cnt_nxt_s = {LAT_W{1'b0}};
          idx_nxt_s     = {IDX_W{1'b0}};
          state_nxt_s   = ST_TX;
        end else begin
          lat_cnt_nxt_s = lat_cnt_r + LAT_W'(1);
        end
      end
      ST_TX: begin
        // A full TX FIFO simply stalls; the shift register keeps its word.
        if (push_s) begin
          shift_nxt_s = shift_r >> DATA_WIDTH;
          if (idx_r == RES_LAST) begin
            idx_nxt_s        = {IDX_W{1'b0}};
            frame_done_nxt_s = 1'b1;
            state_nxt_s      = ST_RX_A;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_TX;
        end
      end
      default: begin
        state_nxt_s = ST_RX_A;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase

    // Idle counter runs only while a partial frame waits on an empty FIFO.
    if (pop_s) begin
      tmo_cnt_nxt_s = {TMO_W{1'b0}};
    end else if (partial_s && i_rx_empty) begin
      tmo_cnt_nxt_s = tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_nxt_s = {TMO_W{1'b0}};
    end

    // Abort discards the partial operands; published outputs are kept.
    if (tmo_hit_s) begin
      state_nxt_s     = ST_RX_A;
      idx_nxt_s       = {IDX_W{1'b0}};
      shadow_a_nxt_s  = {OP_SZ{1'b0}};
      shadow_b_nxt_s  = {OP_SZ{1'b0}};
      tmo_cnt_nxt_s   = {TMO_W{1'b0}};
      frame_err_nxt_s = 1'b1;
    end else begin
      frame_err_nxt_s = 1'b0;
    end

    busy_nxt_s = (state_nxt_s != ST_RX_A) || (idx_nxt_s != {IDX_W{1'b0}});
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r      <= ST_RX_A;
      idx_r        <= {IDX_W{1'b0}};
      shadow_a_r   <= {OP_SZ{1'b0}};
      shadow_b_r   <= {OP_SZ{1'b0}};
      op_a_r       <= {OP_SZ{1'b0}};
      op_b_r       <= {OP_SZ{1'b0}};
      op_code_r    <= {OPCODE_SZ{1'b0}};
      lat_cnt_r    <= {LAT_W{1'b0}};
      shift_r      <= {RES_SZ{1'b0}};
      tmo_cnt_r    <= {TMO_W{1'b0}};
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      shadow_a_r   <= shadow_a_nxt_s;
      shadow_b_r   <= shadow_b_nxt_s;
      op_a_r       <= op_a_nxt_s;
      op_b_r       <= op_b_nxt_s;
      op_code_r    <= op_code_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      shift_r      <= shift_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      busy_r       <= busy_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      frame_err_r  <= frame_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Self-checking bench for uart_alu_frame_ctrl (8-bit words, 2-byte operands
// and result, 6-bit opcode, ALU latency 3, inactivity limit 16 cycles).
// A transaction-level model tracks the RX FIFO contents, the frame byte
// position, expected operands and the pending result bytes, and derives the
// per-cycle expected strobes and pulses from the frame timing rules.
module tb_uart_alu_frame_ctrl;

  localparam int LAT = 3;
  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_rx_empty;
  logic [7:0]  i_r_data;
  logic        i_tx_full;
  logic [15:0] i_result_data;
  logic        o_rd_uart;
  logic        o_wr_uart;
  logic [7:0]  o_w_data;
  logic [15:0] o_op_a;
  logic [15:0] o_op_b;
  logic [5:0]  o_op_code;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_frame_err;

  uart_alu_frame_ctrl #(
    .DATA_WIDTH(8), .OP_BYTES(2), .RES_BYTES(2), .OPCODE_SZ(6),
    .ALU_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_empty(i_rx_empty),
    .i_r_data(i_r_data), .i_tx_full(i_tx_full), .i_result_data(i_result_data),
    .o_rd_uart(o_rd_uart), .o_wr_uart(o_wr_uart), .o_w_data(o_w_data),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_op_code(o_op_code), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  cur[5];
  int          rx_pos, cyc, last_pop, res_cyc, tx_start, done_cyc, err_cyc;
  int          full_hold;
  bit          bp_pending, rand_mode;
  logic [15:0] exp_a, exp_b, res_val, next_res;
  logic [5:0]  exp_code;

  // observation logs
  logic [7:0]  tx_log[$];
  int          push_cyc[$], pop_cyc[$], oppop_cyc[$];
  int          obs_err_cyc, n_done_obs, n_err_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rx_pos = 0; exp_tx.delete();
    exp_a = 16'h0; exp_b = 16'h0; exp_code = 6'h0;
    done_cyc = -100; err_cyc = -100; res_cyc = -100; tx_start = 0;
    last_pop = -1000; full_hold = 0; bp_pending = 1'b0;
  endtask

  task automatic clear_logs();
    tx_log.delete(); push_cyc.delete(); pop_cyc.delete(); oppop_cyc.delete();
  endtask

  task automatic drive_inputs();
    if (rand_mode && rx_q.size() < 4 && $urandom_range(0, 2) == 0)
      rx_q.push_back(8'($urandom));
    i_rx_empty = (rx_q.size() == 0);
    i_r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'hEE;
    if (bp_pending && cyc == tx_start) begin
      full_hold  = 5;
      bp_pending = 1'b0;
    end
    if (full_hold > 0) begin
      i_tx_full = 1'b1;
      full_hold--;
    end else begin
      i_tx_full = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    // The result is only correct in the cycle it must be captured.
    i_result_data = (cyc == res_cyc) ? res_val : ~res_val;
  endtask

  task automatic check_cycle();
    bit phase;
    phase = (exp_tx.size() > 0);
    chk("rd_uart", o_rd_uart, !i_reset && rx_q.size() > 0 && !phase);
    chk("wr_uart", o_wr_uart, !i_reset && phase && cyc >= tx_start && !i_tx_full);
    if (i_reset) chk("w_data_reset", o_w_data, 8'h00);
    else if (phase && cyc >= tx_start) chk("w_data", o_w_data, exp_tx[0]);
    chk("op_a", o_op_a, exp_a);
    chk("op_b", o_op_b, exp_b);
    chk("op_code", o_op_code, exp_code);
    chk("busy", o_busy, !i_reset && (rx_pos > 0 || phase));
    chk("frame_done", o_frame_done, cyc == done_cyc);
    chk("frame_err", o_frame_err, cyc == err_cyc);
  endtask

  task automatic update(input logic rd, input logic wr);
    int ended;
    ended = cyc;
    cyc++;
    if (!i_reset) begin
      if (rd && rx_q.size() > 0) begin
        cur[rx_pos] = rx_q.pop_front();
        rx_pos++;
        last_pop = ended;
        if (rx_pos == 5) begin
          exp_a    = {cur[1], cur[0]};
          exp_b    = {cur[3], cur[2]};
          exp_code = cur[4][5:0];
          rx_pos   = 0;
          oppop_cyc.push_back(ended);
          res_cyc  = ended + LAT;
          tx_start = ended + LAT + 1;
          res_val  = next_res;
          exp_tx.push_back(res_val[7:0]);
          exp_tx.push_back(res_val[15:8]);
          if (rand_mode) next_res = 16'($urandom);
        end
      end
      if (wr && exp_tx.size() > 0) begin
        void'(exp_tx.pop_front());
        if (exp_tx.size() == 0) done_cyc = cyc;
      end
      if (rx_pos > 0 && cyc == last_pop + TMO + 1) begin
        rx_pos  = 0;
        err_cyc = cyc;
      end
    end
  endtask

  task automatic step();
    logic rd, wr;
    drive_inputs();
    @(negedge i_clk);
    check_cycle();
    rd = o_rd_uart;
    wr = o_wr_uart;
    if (wr) begin
      tx_log.push_back(o_w_data);
      push_cyc.push_back(cyc);
    end
    if (rd) pop_cyc.push_back(cyc);
    if (o_frame_done) n_done_obs++;
    if (o_frame_err) begin
      n_err_obs++;
      obs_err_cyc = cyc;
    end
    @(posedge i_clk);
    #1;
    update(rd, wr);
  endtask

  task automatic run_frames(input int n, input int maxc);
    int target;
    target = n_done_obs + n;
    for (int i = 0; i < maxc && n_done_obs < target; i++) step();
    chk("wait_frame_done", n_done_obs >= target, 1'b1);
  endtask

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    rx_q.push_back(b0); rx_q.push_back(b1); rx_q.push_back(b2);
    rx_q.push_back(b3); rx_q.push_back(b4);
  endtask

  initial begin
    int d0, e0;
    cyc = 0; rand_mode = 1'b0; next_res = 16'h0; res_val = 16'h0;
    n_done_obs = 0; n_err_obs = 0; obs_err_cyc = -1;
    model_reset();
    i_reset = 1'b1;

    // reset state
    for (int i = 0; i < 3; i++) step();
    i_reset = 1'b0;
    step();

    // basic frame
    clear_logs();
    d0 = n_done_obs;
    next_res = 16'hACE0;
    push5(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    run_frames(1, 40);
    step(); step();
    chk("basic_op_a", o_op_a, 16'h1234);
    chk("basic_op_b", o_op_b, 16'h5678);
    chk("basic_op_code", o_op_code, 6'h20);
    chk("basic_tx_count", tx_log.size(), 2);
    chk("basic_tx_byte0", tx_log[0], 8'hE0);
    chk("basic_tx_byte1", tx_log[1], 8'hAC);
    chk("basic_done_pulses", n_done_obs - d0, 1);

    // opcode masking
    next_res = 16'h0F0F;
    push5(8'h01, 8'h02, 8'h03, 8'h04, 8'hFF);
    run_frames(1, 40);
    chk("mask_op_code", o_op_code, 6'h3F);

    // back-pressure at TX entry
    clear_logs();
    next_res = 16'hACE0;
    bp_pending = 1'b1;
    push5(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    run_frames(1, 50);
    chk("bp_first_push", push_cyc[0] - oppop_cyc[0], LAT + 1 + 5);
    chk("bp_consecutive", push_cyc[1] - push_cyc[0], 1);
    chk("bp_byte0", tx_log[0], 8'hE0);
    chk("bp_byte1", tx_log[1], 8'hAC);

    // latency and back-to-back frames
    clear_logs();
    next_res = 16'h5AA5;
    push5(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h03);
    push5(8'h11, 8'h22, 8'h33, 8'h44, 8'h05);
    run_frames(2, 80);
    chk("lat_first_push", push_cyc[0] - oppop_cyc[0], LAT + 1);
    chk("b2b_first_pop", pop_cyc[5] - push_cyc[1], 1);
    chk("b2b_op_a", o_op_a, 16'h2211);

    // inactivity abort
    clear_logs();
    e0 = n_err_obs;
    rx_q.push_back(8'h34); rx_q.push_back(8'h12); rx_q.push_back(8'h78);
    for (int i = 0; i < 40 && n_err_obs == e0; i++) step();
    chk("tmo_err_seen", n_err_obs - e0, 1);
    chk("tmo_err_delay", obs_err_cyc - pop_cyc[2], TMO + 1);
    chk("tmo_op_a_kept", o_op_a, 16'h2211);
    chk("tmo_op_b_kept", o_op_b, 16'h4433);
    step();
    next_res = 16'h0003;
    push5(8'h01, 8'h00, 8'h02, 8'h00, 8'h05);
    run_frames(1, 40);
    chk("tmo_next_op_a", o_op_a, 16'h0001);
    chk("tmo_next_op_b", o_op_b, 16'h0002);
    chk("tmo_next_op_code", o_op_code, 6'h05);

    // reset during TX after the first byte
    clear_logs();
    next_res = 16'hBEEF;
    push5(8'h34, 8'h12, 8'h78, 8'h56, 8'h20);
    for (int i = 0; i < 40 && tx_log.size() == 0; i++) step();
    chk("rst_first_byte", tx_log.size(), 1);
    rx_q.push_back(8'h55);
    i_rx_empty = 1'b0;
    i_r_data   = 8'h55;
    i_reset    = 1'b1;
    model_reset();
    #1;
    chk("rst_rd", o_rd_uart, 1'b0);
    chk("rst_wr", o_wr_uart, 1'b0);
    chk("rst_w_data", o_w_data, 8'h00);
    chk("rst_op_a", o_op_a, 16'h0000);
    chk("rst_busy", o_busy, 1'b0);
    step(); step();
    i_reset = 1'b0;
    clear_logs();
    next_res = 16'h1357;
    rx_q.push_back(8'h66); rx_q.push_back(8'h77);
    rx_q.push_back(8'h88); rx_q.push_back(8'h09);
    run_frames(1, 40);
    chk("rst_new_op_a", o_op_a, 16'h6655);
    chk("rst_new_op_b", o_op_b, 16'h8877);
    chk("rst_new_tx0", tx_log[0], 8'h57);
    chk("rst_new_tx1", tx_log[1], 8'h13);

    // randomized traffic with random back-pressure
    d0 = n_done_obs;
    rand_mode = 1'b1;
    next_res = 16'($urandom);
    for (int i = 0; i < 400; i++) step();
    rand_mode = 1'b0;
    for (int i = 0; i < 80; i++) step();
    chk("rand_frames_seen", (n_done_obs - d0) > 5, 1'b1);
    chk("rand_drained", exp_tx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
